rv_register_file: RTL and testbench
===================================

// Module: rv_register_file
// PURPOSE
//   RV32 integer register file for the core's decode/register-read stage.
//   32 x 32-bit registers, two read ports (rs1, rs2) and one write port (rd); x0 is hardwired to zero.
//   Registered read outputs, with write-to-read bypass so a same-cycle write is visible.
//   A block-level enable freezes the whole file (no write, outputs hold) for pipeline stalls.
// PARAMETERS
//   XLEN    32  data width of each register and of the data/read ports
//   NREGS   32  number of architectural registers; x0 is read-only zero
//   ADDR_W  5   register address width, equal to clog2(NREGS)
// PORTS
//   clk                   in   1       single clock; all state updates on rising edge
//   rst                   in   1       synchronous, active-high reset
//   rs1_add               in   ADDR_W  read port 1 register address
//   rs2_add               in   ADDR_W  read port 2 register address
//   rd_add                in   ADDR_W  write port destination register address
//   data                  in   XLEN    write data for rd_add
//   wen                   in   1       write enable, active-high
//   register_file_enable  in   1       block enable; 0 blocks writes and holds the outputs
//   rs1_val               out  XLEN    registered read data for rs1_add
//   rs2_val               out  XLEN    registered read data for rs2_add
// BEHAVIOUR
// - Clocking and reset
//   - One clock domain (clk); reset is synchronous and active-high.
//   - rst=1 at a rising edge: all 32 registers <= 0, rs1_val <= 0, rs2_val <= 0.
//   - rst has priority over enable and wen.
// - Write
//   - At posedge, when register_file_enable=1, wen=1 and rd_add!=0: regs[rd_add] <= data.
//   - A write with rd_add=0 is silently discarded; x0 always reads 0.
// - Read
//   - At posedge, when register_file_enable=1: rsN_val <= value of regs[rsN_add].
//   - Latency is one cycle, measured from the address being presented at the edge.
//   - Bypass: if the same edge also writes rsN_add (and rsN_add!=0), rsN_val takes the new data.
//   - If rsN_add=0, rsN_val <= 0 regardless of any write.
//   - rs1 and rs2 are fully independent and may address the same register.
// - Enable
//   - register_file_enable=0: no register is written, and rs1_val/rs2_val hold their previous values.
// - Unknown inputs
//   - An X/undriven address while enable=1 is not a legal stimulus.
//   - The bench drives addresses before relying on the outputs.
// - Reset mid-operation
//   - A write coincident with rst is lost.
//   - The outputs read 0 on the edge after rst deasserts until new reads complete.
// STRUCTURE
// - Shared package rv_pkg holds:
//   - XLEN and NREGS;
//   - typedef logic [XLEN-1:0] word_t;
//   - typedef logic [ADDR_W-1:0] reg_addr_t;
//   - localparam reg_addr_t REG_ZERO = '0.
// - Storage: word_t regs[NREGS] as a single always_ff block with the write and reset logic.
// - Sub-module rf_read_port, instantiated twice (rs1 and rs2).
//   - Combinational mux plus bypass/zero-detect logic, followed by the output register with hold-on-disable.
// TESTING
// - Reset test
//   - Apply rst for 2 cycles, then enable=1, rs1=3, rs2=31.
//   - Required: rs1_val=0 and rs2_val=0.
// - Basic write then read
//   - enable=1, wen=1: write x1=0x5, then x2=0xA; then wen=0, rs1=1, rs2=2.
//   - Required: after 1 cycle, rs1_val=0x5 and rs2_val=0xA.
// - High register / unwritten register
//   - Write x17=0xB, then read rs1=17, rs2=18.
//   - Required: rs1_val=0xB, rs2_val=0 (x18 is still at its reset value).
// - x0 protection
//   - Write x0=0x2, then read rs1=2, rs2=0.
//   - Required: rs1_val=0xA, rs2_val=0.
// - Bypass
//   - Same edge: wen=1, rd=5, data=0x1234, rs1=5.
//   - Required: rs1_val=0x1234 on that edge.
//   - Also: rd=0 with rs2=0 gives rs2_val=0.
// - Enable gating
//   - enable=0 with wen=1, rd=1, data=0xFF, rs1=1: rs1_val holds its old value.
//   - Re-enable and read x1: required rs1_val=0x5 (the gated write was not performed).

Source files
------------

// File: rtl/rv_pkg.sv
// ============================================================================
// Module      : rv_pkg
// Description : Shared RV32 register-file types and sizing constants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int ADDR_W = $clog2(NREGS);

  typedef logic [XLEN-1:0]   word_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage : rv_pkg

`default_nettype wire

// File: rtl/rf_read_port.sv
// ============================================================================
// Module      : rf_read_port
// Description : One register-file read port: array mux, write bypass, x0
//               zero-detect and an output register that holds when disabled.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_read_port
  import rv_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      i_en,
  input  reg_addr_t i_rs_add,
  input  logic      i_wr,
  input  reg_addr_t i_rd_add,
  input  word_t     i_data,
  input  word_t     i_regs [NREGS],
  output word_t     o_val
);

  word_t w_next;
  word_t r_val;

  // i_wr is already qualified (enabled, wen, rd!=0), so a match means a real write.
  always_comb begin
    w_next = i_regs[i_rs_add];
    if (i_rs_add == REG_ZERO) begin
      w_next = '0;
    end else if (i_wr && (i_rd_add == i_rs_add)) begin
      w_next = i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_val <= '0;
    end else if (i_en) begin
      r_val <= w_next;
    end
  end

  assign o_val = r_val;

endmodule : rf_read_port

`default_nettype wire

// File: rtl/rv_register_file.sv
// ============================================================================
// Module      : rv_register_file
// Description : RV32 integer register file, 2 registered read ports with
//               write bypass, 1 write port, x0 hardwired to zero, stall enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_register_file
  import rv_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  reg_addr_t rs1_add,
  input  reg_addr_t rs2_add,
  input  reg_addr_t rd_add,
  input  word_t     data,
  input  logic      wen,
  input  logic      register_file_enable,
  output word_t     rs1_val,
  output word_t     rs2_val
);

  word_t r_regs [NREGS];
  logic  w_wr;

  assign w_wr = register_file_enable && wen && (rd_add != REG_ZERO);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr) begin
      r_regs[rd_add] <= data;
    end
  end

  rf_read_port u_rs1_port (
    .clk      (clk),
    .rst      (rst),
    .i_en     (register_file_enable),
    .i_rs_add (rs1_add),
    .i_wr     (w_wr),
    .i_rd_add (rd_add),
    .i_data   (data),
    .i_regs   (r_regs),
    .o_val    (rs1_val)
  );

  rf_read_port u_rs2_port (
    .clk      (clk),
    .rst      (rst),
    .i_en     (register_file_enable),
    .i_rs_add (rs2_add),
    .i_wr     (w_wr),
    .i_rd_add (rd_add),
    .i_data   (data),
    .i_regs   (r_regs),
    .o_val    (rs2_val)
  );

endmodule : rv_register_file

`default_nettype wire

// File: tb/tb_rv_register_file.sv
// ============================================================================
// Module      : tb_rv_register_file
// Description : Self-checking bench for rv_register_file: directed scenarios
//               plus randomized traffic against an array-based reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv_register_file;
  import rv_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  reg_addr_t rs1_add, rs2_add, rd_add;
  word_t     data;
  logic      wen, en;
  word_t     rs1_val, rs2_val;

  int n_pass  = 0;
  int n_total = 0;

  // Reference: architectural register contents and the expected read outputs.
  word_t m_regs [NREGS];
  word_t m_rs1, m_rs2;

  always #5 clk = ~clk;

  rv_register_file dut (
    .clk                  (clk),
    .rst                  (rst),
    .rs1_add              (rs1_add),
    .rs2_add              (rs2_add),
    .rd_add               (rd_add),
    .data                 (data),
    .wen                  (wen),
    .register_file_enable (en),
    .rs1_val              (rs1_val),
    .rs2_val              (rs2_val)
  );

  function automatic word_t model_read(input reg_addr_t a);
    if (a == 0) return '0;
    if (en && wen && rd_add == a) return data;
    return m_regs[a];
  endfunction

  // Drives one cycle of stimulus, advances the reference and settles past the edge.
  task automatic cycle(input logic r, input logic e, input logic w, input reg_addr_t rd,
                       input word_t d, input reg_addr_t a1, input reg_addr_t a2);
    rst = r; en = e; wen = w; rd_add = rd; data = d; rs1_add = a1; rs2_add = a2;
    @(posedge clk);
    if (r) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      m_rs1 = '0;
      m_rs2 = '0;
    end else if (e) begin
      m_rs1 = model_read(a1);
      m_rs2 = model_read(a2);
      if (w && rd != 0) m_regs[rd] = d;
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 1, 4, 32'hDEAD, 4, 4);
    n_total++;
    if (rs1_val !== 32'h0 || rs2_val !== 32'h0)
      $display("FAIL reset_hold: rs1_val=%h rs2_val=%h required 0/0", rs1_val, rs2_val);
    else n_pass++;
    cycle(0, 1, 0, 0, 0, 3, 31);
    n_total++;
    if (rs1_val !== 32'h0) $display("FAIL reset_rs1: rs1_val=%h required 0", rs1_val);
    else n_pass++;
    n_total++;
    if (rs2_val !== 32'h0) $display("FAIL reset_rs2: rs2_val=%h required 0", rs2_val);
    else n_pass++;
  endtask

  task automatic test_basic();
    cycle(0, 1, 1, 1, 32'h5, 0, 0);
    cycle(0, 1, 1, 2, 32'hA, 0, 0);
    cycle(0, 1, 0, 0, 0, 1, 2);
    n_total++;
    if (rs1_val !== 32'h5) $display("FAIL basic_rs1: rs1_val=%h required 5", rs1_val);
    else n_pass++;
    n_total++;
    if (rs2_val !== 32'hA) $display("FAIL basic_rs2: rs2_val=%h required a", rs2_val);
    else n_pass++;
  endtask

  task automatic test_high();
    cycle(0, 1, 1, 17, 32'hB, 0, 0);
    cycle(0, 1, 0, 0, 0, 17, 18);
    n_total++;
    if (rs1_val !== 32'hB || rs2_val !== 32'h0)
      $display("FAIL high_reg: rs1_val=%h rs2_val=%h required b/0", rs1_val, rs2_val);
    else n_pass++;
  endtask

  task automatic test_x0();
    cycle(0, 1, 1, 0, 32'h2, 0, 0);
    cycle(0, 1, 0, 0, 0, 2, 0);
    n_total++;
    if (rs1_val !== 32'hA || rs2_val !== 32'h0)
      $display("FAIL x0_protect: rs1_val=%h rs2_val=%h required a/0", rs1_val, rs2_val);
    else n_pass++;
  endtask

  task automatic test_bypass();
    cycle(0, 1, 1, 5, 32'h1234, 5, 6);
    n_total++;
    if (rs1_val !== 32'h1234 || rs2_val !== 32'h0)
      $display("FAIL bypass_rs1: rs1_val=%h rs2_val=%h required 1234/0", rs1_val, rs2_val);
    else n_pass++;
    cycle(0, 1, 1, 0, 32'h7777, 5, 0);
    n_total++;
    if (rs2_val !== 32'h0 || rs1_val !== 32'h1234)
      $display("FAIL bypass_x0: rs1_val=%h rs2_val=%h required 1234/0", rs1_val, rs2_val);
    else n_pass++;
  endtask

  task automatic test_enable();
    cycle(0, 1, 0, 0, 0, 2, 17);
    cycle(0, 0, 1, 1, 32'hFF, 1, 5);
    n_total++;
    if (rs1_val !== 32'hA || rs2_val !== 32'hB)
      $display("FAIL enable_hold: rs1_val=%h rs2_val=%h required a/b", rs1_val, rs2_val);
    else n_pass++;
    cycle(0, 1, 0, 0, 0, 1, 1);
    n_total++;
    if (rs1_val !== 32'h5 || rs2_val !== 32'h5)
      $display("FAIL enable_gated_write: rs1_val=%h rs2_val=%h required 5/5", rs1_val, rs2_val);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    cycle(0, 1, 1, 9, 32'h99, 0, 0);
    cycle(1, 1, 1, 10, 32'hAA, 9, 10);
    cycle(0, 1, 0, 0, 0, 9, 10);
    n_total++;
    if (rs1_val !== 32'h0 || rs2_val !== 32'h0)
      $display("FAIL reset_mid: rs1_val=%h rs2_val=%h required 0/0", rs1_val, rs2_val);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0), $urandom_range(0, 1),
            reg_addr_t'($urandom_range(0, 31)), word_t'($urandom),
            reg_addr_t'($urandom_range(0, 31)), reg_addr_t'($urandom_range(0, 31)));
      n_total++;
      if (rs1_val !== m_rs1 || rs2_val !== m_rs2)
        $display("FAIL random[%0d]: rs1_val=%h rs2_val=%h required %h/%h",
                 k, rs1_val, rs2_val, m_rs1, m_rs2);
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; wen = 1'b0;
    rd_add = '0; rs1_add = '0; rs2_add = '0; data = '0;
    foreach (m_regs[i]) m_regs[i] = '0;
    m_rs1 = '0;
    m_rs2 = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_high();
    test_x0();
    test_bypass();
    test_enable();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_rv_register_file

`default_nettype wire
